// File: rtl/burst_txn_scheduler.sv
// ---------------------------------------------------------------------------
// burst_txn_scheduler
//
// Shares one data burst controller between two requesters. Pending commands
// are arbitrated round-robin. The winning command is latched onto the
// controller configuration outputs, launched with a one-cycle start pulse,
// and then followed through the controller's idle/rd_done handshake. Two
// watchdogs bound the handshake: one for the controller to go busy, one for
// it to return idle. The outcome is reported to the owner as a done pulse
// with an error flag.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid                     command pending from requester N
//   reqN_rw                        1 = write, 0 = read
//   reqN_length                    transfer length in beats (0 is rejected)
//   reqN_max_burst                 max burst size (0 selects DEFAULT_BURST)
//   reqN_ready                     one-cycle accept strobe to the winner
//   reqN_done                      one-cycle completion pulse to the owner
//   req_err                        qualifies the done pulse; 1 = failed
//   sch_db_start                   one-cycle start to the burst controller
//   sch_db_rw / _length /
//   sch_db_max_burst_size          command configuration, stable while busy
//   sch_db_idle_in                 controller idle (1 = idle)
//   sch_db_rd_done_in              controller read-done flag
//   sch_busy                       high from grant until the done pulse
// ---------------------------------------------------------------------------
module burst_txn_scheduler #(
   parameter logic [7:0] DEFAULT_BURST = 8'd4,
   parameter int         BUSY_TIMEOUT  = 4,
   parameter int         DONE_TIMEOUT  = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   input  logic       req0_rw,
   input  logic [7:0] req0_length,
   input  logic [7:0] req0_max_burst,
   output logic       req0_ready,
   output logic       req0_done,
   input  logic       req1_valid,
   input  logic       req1_rw,
   input  logic [7:0] req1_length,
   input  logic [7:0] req1_max_burst,
   output logic       req1_ready,
   output logic       req1_done,
   output logic       req_err,
   output logic       sch_db_start,
   output logic       sch_db_rw,
   output logic [7:0] sch_db_length,
   output logic [7:0] sch_db_max_burst_size,
   input  logic       sch_db_idle_in,
   input  logic       sch_db_rd_done_in,
   output logic       sch_busy
);

   localparam logic [15:0] BUSY_LIMIT = 16'(BUSY_TIMEOUT);
   localparam logic [15:0] DONE_LIMIT = 16'(DONE_TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_START,
      ST_WAIT_BUSY,
      ST_WAIT_IDLE,
      ST_COMPLETE
   } state_t;

   state_t      state_reg;
   logic        last_grant_reg;
   logic        owner_reg;
   logic        rd_seen_reg;
   logic [15:0] cnt_reg;

   logic        any_valid;
   logic        winner;
   logic        sel_rw;
   logic [7:0]  sel_length;
   logic [7:0]  sel_burst;
   logic [15:0] cnt_inc;
   logic        finish;
   logic        finish_err;

   always_comb begin
      any_valid  = req0_valid | req1_valid;
      // With both pending, the requester that did not win last time goes.
      winner     = (req0_valid & req1_valid) ? ~last_grant_reg : req1_valid;
      sel_rw     = winner ? req1_rw : req0_rw;
      sel_length = winner ? req1_length : req0_length;
      sel_burst  = winner ? req1_max_burst : req0_max_burst;
      if (sel_burst == 8'd0) begin
         sel_burst = DEFAULT_BURST;
      end

      // Saturating increment so a stuck counter can never wrap to zero.
      cnt_inc = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

      // Every route into COMPLETE, with the error it reports.
      finish     = 1'b0;
      finish_err = 1'b0;
      case (state_reg)
         ST_GRANT: begin
            if (sch_db_length == 8'd0) begin
               finish     = 1'b1;
               finish_err = 1'b1;
            end
         end
         ST_WAIT_BUSY: begin
            if (sch_db_idle_in && (cnt_inc >= BUSY_LIMIT)) begin
               finish     = 1'b1;
               finish_err = 1'b1;
            end
         end
         ST_WAIT_IDLE: begin
            if (sch_db_idle_in) begin
               finish     = 1'b1;
               // A read that finished without ever flagging rd_done is bad;
               // a flag on the very cycle idle returns still counts.
               finish_err = ~sch_db_rw & ~rd_seen_reg & ~sch_db_rd_done_in;
            end else if (cnt_inc >= DONE_LIMIT) begin
               finish     = 1'b1;
               finish_err = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg             <= ST_IDLE;
         last_grant_reg        <= 1'b1;
         owner_reg             <= 1'b0;
         rd_seen_reg           <= 1'b0;
         cnt_reg               <= 16'd0;
         req0_ready            <= 1'b0;
         req1_ready            <= 1'b0;
         req0_done             <= 1'b0;
         req1_done             <= 1'b0;
         req_err               <= 1'b0;
         sch_db_start          <= 1'b0;
         sch_db_rw             <= 1'b0;
         sch_db_length         <= 8'd0;
         sch_db_max_burst_size <= 8'd0;
         sch_busy              <= 1'b0;
      end else begin
         // Strobes default low; each is raised for exactly one cycle.
         req0_ready   <= 1'b0;
         req1_ready   <= 1'b0;
         req0_done    <= 1'b0;
         req1_done    <= 1'b0;
         req_err      <= 1'b0;
         sch_db_start <= 1'b0;

         if (finish) begin
            state_reg <= ST_COMPLETE;
            req0_done <= ~owner_reg;
            req1_done <= owner_reg;
            req_err   <= finish_err;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  // No grant while the controller is still busy.
                  if (any_valid && sch_db_idle_in) begin
                     state_reg             <= ST_GRANT;
                     owner_reg             <= winner;
                     last_grant_reg        <= winner;
                     req0_ready            <= ~winner;
                     req1_ready            <= winner;
                     sch_db_rw             <= sel_rw;
                     sch_db_length         <= sel_length;
                     sch_db_max_burst_size <= sel_burst;
                     sch_busy              <= 1'b1;
                  end
               end
               ST_GRANT: begin
                  state_reg    <= ST_START;
                  sch_db_start <= 1'b1;
               end
               ST_START: begin
                  state_reg   <= ST_WAIT_BUSY;
                  cnt_reg     <= 16'd0;
                  rd_seen_reg <= 1'b0;
               end
               ST_WAIT_BUSY: begin
                  if (!sch_db_idle_in) begin
                     state_reg <= ST_WAIT_IDLE;
                     cnt_reg   <= 16'd0;
                  end else begin
                     cnt_reg <= cnt_inc;
                  end
               end
               ST_WAIT_IDLE: begin
                  if (sch_db_rd_done_in) begin
                     rd_seen_reg <= 1'b1;
                  end
                  cnt_reg <= cnt_inc;
               end
               ST_COMPLETE: begin
                  state_reg <= ST_IDLE;
                  sch_busy  <= 1'b0;
               end
               default: begin
                  state_reg <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_burst_txn_scheduler.sv
// ---------------------------------------------------------------------------
// tb_burst_txn_scheduler
//
// Directed and randomized transactions against burst_txn_scheduler. A small
// controller model drives idle/rd_done relative to the observed start pulse.
// Expected winner, completion latency and error flag come from closed-form
// rules: round-robin over pending requesters, and busy/done watchdog windows
// measured in cycles after the start pulse.
// ---------------------------------------------------------------------------
module tb_burst_txn_scheduler;

   localparam int BUSY_TO = 4;
   localparam int DONE_TO = 1023;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_rw, req0_ready, req0_done;
   logic [7:0] req0_length, req0_max_burst;
   logic       req1_valid, req1_rw, req1_ready, req1_done;
   logic [7:0] req1_length, req1_max_burst;
   logic       req_err;
   logic       sch_db_start, sch_db_rw;
   logic [7:0] sch_db_length, sch_db_max_burst_size;
   logic       sch_db_idle_in, sch_db_rd_done_in;
   logic       sch_busy;

   int errors = 0;
   int checks = 0;

   logic       last_model;
   logic       pend [2];
   logic       c_rw [2];
   logic [7:0] c_len [2];
   logic [7:0] c_mb [2];
   int         served [2];

   always #5 clk = ~clk;

   burst_txn_scheduler dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .req0_valid            (req0_valid),
      .req0_rw               (req0_rw),
      .req0_length           (req0_length),
      .req0_max_burst        (req0_max_burst),
      .req0_ready            (req0_ready),
      .req0_done             (req0_done),
      .req1_valid            (req1_valid),
      .req1_rw               (req1_rw),
      .req1_length           (req1_length),
      .req1_max_burst        (req1_max_burst),
      .req1_ready            (req1_ready),
      .req1_done             (req1_done),
      .req_err               (req_err),
      .sch_db_start          (sch_db_start),
      .sch_db_rw             (sch_db_rw),
      .sch_db_length         (sch_db_length),
      .sch_db_max_burst_size (sch_db_max_burst_size),
      .sch_db_idle_in        (sch_db_idle_in),
      .sch_db_rd_done_in     (sch_db_rd_done_in),
      .sch_busy              (sch_busy)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] out_vec();
      return 32'({req0_ready, req1_ready, req0_done, req1_done, req_err, sch_db_start,
                  sch_db_rw, sch_db_length, sch_db_max_burst_size, sch_busy});
   endfunction

   // Outcome of a started command given the controller behaviour:
   // idle low during cycles [d, d+l) after start, rd_done pulse at cycle r.
   function automatic void model_ctl(input logic rw, input int d, input int l, input int r,
                                     output int lat, output logic err);
      if (d > BUSY_TO) begin
         lat = BUSY_TO + 1;
         err = 1'b1;
      end else if (l - 1 >= DONE_TO) begin
         lat = d + 1 + DONE_TO;
         err = 1'b1;
      end else begin
         lat = d + l + 1;
         err = !rw && !(r >= d + 1 && r <= d + l);
      end
   endfunction

   task automatic drive_cmds();
      req0_valid     = pend[0];
      req0_rw        = c_rw[0];
      req0_length    = c_len[0];
      req0_max_burst = c_mb[0];
      req1_valid     = pend[1];
      req1_rw        = c_rw[1];
      req1_length    = c_len[1];
      req1_max_burst = c_mb[1];
   endtask

   task automatic set_cmd(input int n, input logic rw, input logic [7:0] len, input logic [7:0] mb);
      pend[n]  = 1'b1;
      c_rw[n]  = rw;
      c_len[n] = len;
      c_mb[n]  = mb;
   endtask

   // One transaction from the current pending set. Called at a negedge.
   task automatic do_txn(input int d, input int l, input int r, input int rst_at, output int obs_w);
      logic       w, got, exp_err, exp_rw;
      logic [7:0] exp_len, exp_mb;
      int         lat, since, starts, t;
      obs_w = -1;
      drive_cmds();
      w = (pend[0] && pend[1]) ? ~last_model : pend[1];
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) got = 1'b1;
      end
      chk(32'(got), 32'd1, "ready_seen");
      if (!got) return;
      obs_w = req1_ready ? 1 : 0;
      chk(32'({req1_ready, req0_ready}), w ? 32'd2 : 32'd1, "ready_owner");
      chk(32'(sch_busy), 32'd1, "busy_at_grant");
      chk(32'(req_err), 32'd0, "err_at_grant");
      exp_rw  = c_rw[w];
      exp_len = c_len[w];
      exp_mb  = (c_mb[w] == 8'd0) ? 8'd4 : c_mb[w];
      chk(32'(sch_db_rw), 32'(exp_rw), "cfg_rw");
      chk(32'(sch_db_length), 32'(exp_len), "cfg_length");
      chk(32'(sch_db_max_burst_size), 32'(exp_mb), "cfg_burst");
      last_model = w;
      pend[w] = 1'b0;
      drive_cmds();
      lat = 0;
      exp_err = 1'b1;
      if (exp_len != 8'd0) model_ctl(exp_rw, d, l, r, lat, exp_err);

      since  = -1;
      starts = 0;
      got    = 1'b0;
      for (t = 1; t <= 1400; t++) begin
         @(negedge clk);
         if (sch_db_start) begin
            starts++;
            if (since < 0) since = 0;
            else since++;
         end else if (since >= 0) begin
            since++;
         end
         if (rst_at >= 0 && since == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk(out_vec(), 32'd0, "reset_outputs");
            sch_db_idle_in    = 1'b1;
            sch_db_rd_done_in = 1'b0;
            repeat (2) begin
               @(negedge clk);
               chk(32'({req1_done, req0_done}), 32'd0, "no_done_in_reset");
            end
            rst_n = 1'b1;
            last_model = 1'b1;
            $display("txn owner=%0d rw=%0d len=%0d aborted by reset", w, exp_rw, exp_len);
            return;
         end
         if (req0_done || req1_done) begin
            got = 1'b1;
            break;
         end
         sch_db_idle_in    = !(since >= 0 && since >= d && since < d + l);
         sch_db_rd_done_in = (since >= 0 && since == r);
      end
      sch_db_idle_in    = 1'b1;
      sch_db_rd_done_in = 1'b0;
      chk(32'(got), 32'd1, "done_seen");
      if (got) begin
         chk(32'({req1_done, req0_done}), w ? 32'd2 : 32'd1, "done_owner");
         chk(32'(req_err), 32'(exp_err), "done_err");
         chk(32'(starts), (exp_len == 8'd0) ? 32'd0 : 32'd1, "start_count");
         if (exp_len == 8'd0) chk(32'(t), 32'd1, "done_time_len0");
         else chk(32'(since), 32'(lat), "done_latency");
         chk(32'(sch_db_length), 32'(exp_len), "length_hold");
         chk(32'(sch_db_max_burst_size), 32'(exp_mb), "burst_hold");
      end
      @(negedge clk);
      chk(32'(sch_busy), 32'd0, "busy_drop");
      chk(32'({req1_done, req0_done}), 32'd0, "single_done");
      $display("txn owner=%0d rw=%0d len=%0d burst=%0d err=%0d lat=%0d starts=%0d",
               w, exp_rw, exp_len, exp_mb, req_err, since, starts);
   endtask

   initial begin
      int ow, d, l, r;
      rst_n             = 1'b0;
      sch_db_idle_in    = 1'b1;
      sch_db_rd_done_in = 1'b0;
      for (int n = 0; n < 2; n++) begin
         pend[n] = 1'b0; c_rw[n] = 1'b0; c_len[n] = 8'd0; c_mb[n] = 8'd0; served[n] = 0;
      end
      drive_cmds();
      last_model = 1'b1;
      repeat (3) @(negedge clk);
      chk(out_vec(), 32'd0, "reset_state");

      // Both requesters held valid from reset: strict alternation from req0.
      set_cmd(0, 1'b1, 8'd6, 8'd2);
      set_cmd(1, 1'b1, 8'd9, 8'd3);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         do_txn(2, 6, -1, -1, ow);
         chk(32'(ow), 32'(i % 2), "rr_order");
         if (ow >= 0) begin
            served[ow]++;
            if (served[ow] < 3) set_cmd(ow, 1'b1, 8'(10 + i), 8'(i));
         end
      end

      // Write, length 8, burst 4; idle drops 2 cycles after start for 20.
      set_cmd(0, 1'b1, 8'd8, 8'd4);
      do_txn(2, 20, -1, -1, ow);

      // Read with rd_done inside the busy window, then without it.
      set_cmd(1, 1'b0, 8'd5, 8'd8);
      do_txn(2, 10, 6, -1, ow);
      set_cmd(1, 1'b0, 8'd5, 8'd8);
      do_txn(2, 10, -100, -1, ow);
      // rd_done on the same cycle idle returns still counts.
      set_cmd(1, 1'b0, 8'd5, 8'd8);
      do_txn(3, 4, 7, -1, ow);

      // Zero length is rejected without a start; zero burst takes the default.
      set_cmd(0, 1'b1, 8'd0, 8'd7);
      do_txn(2, 5, -1, -1, ow);
      set_cmd(0, 1'b1, 8'd3, 8'd0);
      do_txn(1, 3, -1, -1, ow);

      // Busy watchdog: idle drops one cycle too late, and never.
      set_cmd(0, 1'b1, 8'd4, 8'd2);
      do_txn(4, 3, -1, -1, ow);
      set_cmd(1, 1'b1, 8'd4, 8'd2);
      do_txn(5, 3, -1, -1, ow);
      set_cmd(0, 1'b1, 8'd4, 8'd2);
      do_txn(100000, 3, -1, -1, ow);

      // Done watchdog: idle never returns.
      set_cmd(1, 1'b0, 8'd12, 8'd4);
      do_txn(2, 100000, 5, -1, ow);

      // Reset in WAIT_IDLE aborts silently; req0 then wins the first tie.
      set_cmd(1, 1'b1, 8'd20, 8'd4);
      do_txn(2, 30, -1, 10, ow);
      set_cmd(0, 1'b1, 8'd7, 8'd1);
      set_cmd(1, 1'b0, 8'd7, 8'd1);
      do_txn(1, 4, 3, -1, ow);
      chk(32'(ow), 32'd0, "first_after_reset");

      // Randomized traffic.
      for (int i = 0; i < 24; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && ($urandom_range(0, 2) != 0)) begin
               set_cmd(n, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
                       8'($urandom_range(0, 255)));
            end
         end
         if (!pend[0] && !pend[1]) set_cmd(int'($urandom_range(0, 1)), 1'b1, 8'd1, 8'd1);
         d = int'($urandom_range(1, 5));
         l = int'($urandom_range(1, 30));
         r = ($urandom_range(0, 2) == 0) ? -100 : int'($urandom_range(0, 40));
         do_txn(d, l, r, -1, ow);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
